// File: rtl/regfile_wb_arbiter.sv
// Purpose : shares the register file's single write port between the ALU and LSU writeback paths and keeps a per-register busy scoreboard.
// Latency : a handshake in cycle N appears on rf_we/rf_waddr/rf_wdata in cycle N+1. The register file captures it at the end of N+1.
// Backpressure: ready depends only on the valid inputs and the arbitration state. A stalled requester holds rd/data until it is accepted.
//
// Build option: define WBARB_RR_EN to replace fixed LSU-over-ALU priority with
// a 1-bit round-robin pointer. The pointer resets to favour the LSU.
//
// Ports
//   clk, rst_n                         clock, asynchronous active-low reset
//   alu_valid/alu_ready/alu_rd/alu_data  ALU writeback request
//   lsu_valid/lsu_ready/lsu_rd/lsu_data  load writeback request
//   rsv_valid/rsv_ready/rsv_rd         destination reservation from decode
//                                      (rsv_ready low = WAW stall)
//   rf_we/rf_waddr/rf_wdata            registered register-file write port
//   busy                               scoreboard, bit r = write to r pending
//   wb_idle                            nothing reserved, nothing in flight
module regfile_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,

    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [ADDR_WIDTH-1:0]        alu_rd,
    input  logic [DATA_WIDTH-1:0]        alu_data,

    input  logic                         lsu_valid,
    output logic                         lsu_ready,
    input  logic [ADDR_WIDTH-1:0]        lsu_rd,
    input  logic [DATA_WIDTH-1:0]        lsu_data,

    input  logic                         rsv_valid,
    output logic                         rsv_ready,
    input  logic [ADDR_WIDTH-1:0]        rsv_rd,

    output logic                         rf_we,
    output logic [ADDR_WIDTH-1:0]        rf_waddr,
    output logic [DATA_WIDTH-1:0]        rf_wdata,

    output logic [(2**ADDR_WIDTH)-1:0]   busy,
    output logic                         wb_idle
);

    localparam int NREG = 2**ADDR_WIDTH;

    logic                  lsu_grant;
    logic                  alu_grant;
    logic                  wb_fire;
    logic [ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;

    logic [NREG-1:0]       busy_q;
    logic [NREG-1:0]       busy_next;
    logic                  rsv_fire;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef WBARB_RR_EN
    // fav_lsu=1 means the LSU wins the next tie.
    logic fav_lsu;

    always_comb begin
        lsu_grant = lsu_valid && (!alu_valid || fav_lsu);
        alu_grant = alu_valid && (!lsu_valid || !fav_lsu);
    end

    // After any grant, the other requester wins the next tie. This covers
    // the single-requester case too. The pointer holds on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fav_lsu <= 1'b1;
        end else if (lsu_grant) begin
            fav_lsu <= 1'b0;
        end else if (alu_grant) begin
            fav_lsu <= 1'b1;
        end
    end
`else
    // Fixed priority. Loads win, because the pipeline never issues loads
    // back-to-back for unbounded time.
    always_comb begin
        lsu_grant = lsu_valid;
        alu_grant = alu_valid && !lsu_valid;
    end
`endif

    assign lsu_ready = lsu_grant;
    assign alu_ready = alu_grant;

    assign wb_fire = lsu_grant || alu_grant;
    assign wb_rd   = lsu_grant ? lsu_rd   : alu_rd;
    assign wb_data = lsu_grant ? lsu_data : alu_data;

    // ------------------------------------------------------------------
    // Registered write port
    // A write to x0 is accepted but never enables the register file.
    // The address and data hold when idle, so the port only toggles on
    // real transfers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (wb_fire) begin
            rf_we    <= (wb_rd != '0);
            rf_waddr <= wb_rd;
            rf_wdata <= wb_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Destination scoreboard
    // The clear happens on the edge where the register file captures the
    // data. A reader that sees busy=0 therefore sees the new value.
    // A same-index set on that edge belongs to a younger instruction, so it
    // is applied after the clear and wins.
    // ------------------------------------------------------------------
    assign rsv_ready = (rsv_rd == '0) || !busy_q[rsv_rd];
    assign rsv_fire  = rsv_valid && rsv_ready && (rsv_rd != '0);

    always_comb begin
        busy_next = busy_q;
        if (rf_we) begin
            busy_next[rf_waddr] = 1'b0;
        end
        if (rsv_fire) begin
            busy_next[rsv_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy    = busy_q;
    assign wb_idle = (busy_q == '0) && !rf_we && !alu_valid && !lsu_valid;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 1 << AW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            alu_valid = 1'b0;
    logic            alu_ready;
    logic [AW-1:0]   alu_rd = '0;
    logic [DW-1:0]   alu_data = '0;
    logic            lsu_valid = 1'b0;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_rd = '0;
    logic [DW-1:0]   lsu_data = '0;
    logic            rsv_valid = 1'b0;
    logic            rsv_ready;
    logic [AW-1:0]   rsv_rd = '0;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata;
    logic [NREG-1:0] busy;
    logic            wb_idle;

    regfile_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rsv_valid(rsv_valid), .rsv_ready(rsv_ready), .rsv_rd(rsv_rd),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy), .wb_idle(wb_idle)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: the set of pending destinations, the last write
    // presented, and which requester wins the next tie.
    bit            m_busy [NREG];
    bit            m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    bit            m_fav_lsu;
    bit            g_alu, g_lsu;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREG-1:0] busy_vec();
        logic [NREG-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        m_we      = 1'b0;
        m_waddr   = '0;
        m_wdata   = '0;
        m_fav_lsu = 1'b1;
    endtask

    // Entered and left at posedge+1. The reset pulse stays strictly between
    // edges, so the checks below see the asynchronous clear.
    task automatic do_reset();
        alu_valid = 0; lsu_valid = 0; rsv_valid = 0;
        alu_rd = '0; lsu_rd = '0; rsv_rd = '0; alu_data = '0; lsu_data = '0;
        rst_n = 1'b0;
        #2;
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_busy", busy, 0);
        #1 rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    // One clock cycle: drive, check the combinational outputs, clock, update
    // the model, then check the registered outputs.
    task automatic cycle(input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                         input bit lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                         input bit rv, input logic [AW-1:0] rrd);
        bit e_rsv, e_idle;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        rsv_valid = rv; rsv_rd = rrd;
        #1;
`ifdef WBARB_RR_EN
        if (av && lv) begin
            g_lsu = m_fav_lsu;
            g_alu = !m_fav_lsu;
        end else begin
            g_lsu = lv;
            g_alu = av;
        end
`else
        g_lsu = lv;
        g_alu = av && !lv;
`endif
        e_rsv  = (rrd == 0) || !m_busy[rrd];
        e_idle = (busy_vec() == 0) && !m_we && !av && !lv;
        chk("lsu_ready", lsu_ready, g_lsu);
        chk("alu_ready", alu_ready, g_alu);
        chk("rsv_ready", rsv_ready, e_rsv);
        chk("wb_idle", wb_idle, e_idle);
        @(posedge clk); #1;
        if (m_we) m_busy[m_waddr] = 1'b0;
        if (rv && e_rsv && rrd != 0) m_busy[rrd] = 1'b1;
        if (g_lsu) begin
            m_we = (lrd != 0); m_waddr = lrd; m_wdata = ld;
        end else if (g_alu) begin
            m_we = (ard != 0); m_waddr = ard; m_wdata = ad;
        end else begin
            m_we = 1'b0;
        end
        if (g_lsu) m_fav_lsu = 1'b0;
        else if (g_alu) m_fav_lsu = 1'b1;
        chk("rf_we", rf_we, m_we);
        chk("rf_waddr", rf_waddr, m_waddr);
        chk("rf_wdata", rf_wdata, m_wdata);
        chk("busy", busy, busy_vec());
    endtask

    task automatic idle_cycle();
        cycle(0, '0, '0, 0, '0, '0, 0, '0);
    endtask

    initial begin
        bit            a_v, l_v, r_v, exp_l;
        logic [AW-1:0] a_rd, l_rd, r_rd;
        logic [DW-1:0] a_d, l_d;

        model_reset();
        @(posedge clk); #1;
        do_reset();

        // Single ALU write.
        cycle(1, 5'd5, 32'hDEADBEEF, 0, '0, '0, 0, '0);
        chk("alu_wr_we", rf_we, 1);
        chk("alu_wr_addr", rf_waddr, 5);
        chk("alu_wr_data", rf_wdata, 32'hDEADBEEF);
        idle_cycle();
        chk("alu_wr_drop_we", rf_we, 0);
        chk("alu_wr_hold_addr", rf_waddr, 5);

        // Contention: the LSU wins first, then the held ALU request goes.
        cycle(1, 5'd4, 32'h22, 1, 5'd3, 32'h11, 0, '0);
        chk("cont_addr0", rf_waddr, 3);
        chk("cont_data0", rf_wdata, 32'h11);
        cycle(1, 5'd4, 32'h22, 0, '0, '0, 0, '0);
        chk("cont_addr1", rf_waddr, 4);
        chk("cont_data1", rf_wdata, 32'h22);

        // A write to x0 is accepted but never enables the register file.
        cycle(1, 5'd0, 32'hFFFFFFFF, 0, '0, '0, 0, '0);
        chk("x0_we", rf_we, 0);
        chk("x0_busy0", busy[0], 0);

        // Scoreboard set, WAW stall, clear on commit, and same-edge set wins.
        cycle(0, '0, '0, 0, '0, '0, 1, 5'd7);
        chk("sb_set7", busy[7], 1);
        cycle(0, '0, '0, 0, '0, '0, 1, 5'd7);
        chk("sb_waw7", rsv_ready, 0);
        cycle(0, '0, '0, 1, 5'd7, 32'hA5, 0, 5'd7);
        chk("sb_commit_we", rf_we, 1);
        chk("sb_still7", busy[7], 1);
        cycle(0, '0, '0, 0, '0, '0, 0, 5'd7);
        chk("sb_clear7", busy[7], 0);
        chk("sb_rsv7_ok", rsv_ready, 1);
        cycle(1, 5'd9, 32'h99, 0, '0, '0, 0, '0);
        cycle(0, '0, '0, 0, '0, '0, 1, 5'd9);
        chk("sb_same_edge9", busy[9], 1);
        cycle(1, 5'd9, 32'h9A, 0, '0, '0, 0, '0);
        idle_cycle();

        // Fairness with both requesters held valid for four cycles.
        do_reset();
        l_rd = 5'd10;
        a_rd = 5'd20;
        for (int i = 0; i < 4; i++) begin
            cycle(1, a_rd, {27'd0, a_rd}, 1, l_rd, {27'd0, l_rd}, 0, '0);
`ifdef WBARB_RR_EN
            exp_l = (i % 2 == 0);
`else
            exp_l = 1'b1;
`endif
            chk("fair_addr", rf_waddr, exp_l ? l_rd : a_rd);
            if (exp_l) l_rd = l_rd + 1'b1;
            else a_rd = a_rd + 1'b1;
        end

        // Reset mid-stream with a reservation and a write in flight.
        do_reset();
        cycle(1, 5'd5, 32'h0ABC, 0, '0, '0, 1, 5'd7);
        chk("mid_we", rf_we, 1);
        chk("mid_busy7", busy[7], 1);
        do_reset();
        idle_cycle();
        chk("post_rst_idle", wb_idle, 1);

        // Randomised traffic. A stalled request holds its rd and data.
        a_v = 0; l_v = 0; r_v = 0;
        a_rd = '0; l_rd = '0; r_rd = '0; a_d = '0; l_d = '0;
        for (int n = 0; n < 400; n++) begin
            if (!(a_v && !g_alu)) begin
                a_v  = ($urandom_range(0, 2) != 0);
                a_rd = AW'($urandom_range(0, 7));
                a_d  = DW'($urandom);
            end
            if (!(l_v && !g_lsu)) begin
                l_v  = ($urandom_range(0, 2) == 0);
                l_rd = AW'($urandom_range(0, 7));
                l_d  = DW'($urandom);
            end
            r_v  = ($urandom_range(0, 1) == 1);
            r_rd = AW'($urandom_range(0, 7));
            g_alu = 0; g_lsu = 0;
            cycle(a_v, a_rd, a_d, l_v, l_rd, l_d, r_v, r_rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single synchronous write port between two writeback sources: the ALU/execute path and the load/store unit.
- Registers the granted write onto the register file write port.
- Keeps a destination scoreboard: a busy bit per architectural register, set at issue and cleared at commit. Decode uses it for RAW/WAW stalls.

Parameters:
- ADDR_WIDTH, 5, register index width; the register count is 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register data width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted this cycle.
- alu_rd  in  ADDR_WIDTH  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- lsu_valid  in  1  load writeback request.
- lsu_ready  out  1  load request accepted this cycle.
- lsu_rd  in  ADDR_WIDTH  load destination register.
- lsu_data  in  DATA_WIDTH  load data.
- rsv_valid  in  1  decode reserves a destination at issue.
- rsv_ready  out  1  reservation accepted (low = WAW stall).
- rsv_rd  in  ADDR_WIDTH  register being reserved.
- rf_we  out  1  register file write enable.
- rf_waddr  out  ADDR_WIDTH  register file write address (A3).
- rf_wdata  out  DATA_WIDTH  register file write data (WD3).
- busy  out  2**ADDR_WIDTH  scoreboard; bit r = write to register r pending.
- wb_idle  out  1  no pending reservation and no write in flight.

Behaviour:
- Reset (async, rst_n=0):
  - rf_we=0, rf_waddr=0, rf_wdata=0, busy=0.
  - Round-robin pointer (if present) = LSU-favoured.
  - Takes effect immediately, mid-operation included. In-flight requests are dropped; requesters must re-issue after reset.
- Handshake:
  - A transfer occurs when valid && ready on the rising edge.
  - ready is combinational from the valid inputs and arbitration state only, never from data.
  - A requester holding valid=1 with ready=0 must keep rd/data stable until accepted.
- Arbitration (default fixed priority, LSU over ALU):
  - lsu_ready = lsu_valid.
  - alu_ready = alu_valid && !lsu_valid.
  - At most one transfer per cycle. Throughput is 1 write/cycle.
- Output stage:
  - On the edge where a transfer occurs: rf_we <= (rd != 0), rf_waddr <= rd, rf_wdata <= data.
  - With no transfer: rf_we <= 0; rf_waddr/rf_wdata hold their previous values.
  - Latency: the handshake in cycle N is presented on the write port in cycle N+1 and written into the register file at the end of N+1.
- x0 handling:
  - A write with rd=0 is accepted (ready as normal) but produces rf_we=0.
  - busy[0] is constant 0.
  - A reservation with rsv_rd=0 is always accepted and sets nothing.
- Scoreboard:
  - Set: busy[rsv_rd] <= 1 on rsv_valid && rsv_ready && rsv_rd != 0.
  - Clear: busy[rf_waddr] <= 0 on any edge with rf_we=1, i.e. the same edge the register file captures the data. A consumer that sees busy=0 therefore reads the new value.
  - rsv_ready = (rsv_rd == 0) || !busy[rsv_rd], combinational.
  - A write to a non-busy register is legal; the clear is a no-op.
  - Set and clear of the same index on the same edge: set wins (a new reservation supersedes the committing older write).
  - A set and a clear of different indices on the same edge both take effect.
- wb_idle = (busy == 0) && !rf_we && !alu_valid && !lsu_valid.

Optional Feature:
- Macro: WBARB_RR_EN.
- Defined:
  - A 1-bit round-robin pointer replaces fixed priority. It resets to favour the LSU.
  - When both requesters are valid, the favoured one is granted; the pointer then flips to favour the other.
  - A grant with only one requester valid sets the pointer to favour the non-granted requester.
  - The pointer holds when nothing is granted.
- Not defined: fixed LSU priority, no pointer flop. The ALU can be starved by back-to-back loads; the pipeline guarantees loads are not back-to-back for unbounded time.

Test Plan:
- Reset mid-stream: rsv rd=7 accepted, ALU write rd=5 in flight, then rst_n=0 for one cycle between edges → rf_we=0, busy=0 immediately without a clock edge; after release, wb_idle=1.
- Single ALU write: alu_valid=1, rd=5, data=0xDEADBEEF → alu_ready=1 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; following cycle rf_we=0, rf_waddr still 5.
- Contention (macro off): lsu rd=3 data=0x11 and alu rd=4 data=0x22 both valid → cycle 0: lsu_ready=1, alu_ready=0; cycle 1: alu_ready=1. rf_we pulses for addr 3 then addr 4 on consecutive cycles with matching data.
- x0 write: alu_valid=1, rd=0, data=0xFFFFFFFF → alu_ready=1; rf_we stays 0; busy[0]=0 throughout.
- Scoreboard:
  - rsv rd=7 → busy[7]=1 next cycle.
  - Second rsv rd=7 → rsv_ready=0.
  - lsu write rd=7 data=0xA5 → busy[7] clears on the edge where rf_we=1, rf_waddr=7; rsv_ready for rd=7 returns to 1 the following cycle.
  - Same-edge rsv rd=9 (not busy) while rf_we=1, rf_waddr=9 → busy[9]=1 afterwards.
- Fairness: both requesters valid for 4 consecutive cycles.
  - Macro on → grants lsu, alu, lsu, alu.
  - Macro off → lsu four times, alu_ready=0 throughout.
